digital_lock_ctrl: RTL and testbench

Parametrised serial code lock that replaces the fixed 4-bit lock. It collects a CODE_LEN-bit code MSB-first from a valid-qualified bit stream and judges the whole entry only after the last bit, so a wrong bit is never revealed early. Repeated failures trigger a timed lockout, and the unlock is timed. When unlocked, the code can be reprogrammed. Sits between the keypad/serial front end and the actuator/status logic.

---
 rtl/digital_lock_pkg.sv | 20 ++
 rtl/lock_cycle_timer.sv | 29 ++
 rtl/digital_lock_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_digital_lock_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/digital_lock_pkg.sv
// Shared types and sizing helpers for the serial code lock.
package digital_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        PROG     = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    // Width of a down-counter that must hold the largest of three durations.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lock_cycle_timer.sv
// Loadable down-counter; expired is high during the last counted cycle.
module lock_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == W'(1));

endmodule

// File: rtl/digital_lock_ctrl.sv
// Serial code lock: MSB-first entry judged only after the last bit, timed
// unlock, fail-count lockout and in-place code reprogramming.
module digital_lock_ctrl
    import digital_lock_pkg::*;
#(
    parameter int                  CODE_LEN       = 8,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = CODE_LEN'(8'hB5),
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 16,
    parameter int                  UNLOCK_CYCLES  = 32,
    parameter int                  ENTRY_TIMEOUT  = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           I_VALID,
    input  logic                           I_BIT,
    input  logic                           I_PROG,
    input  logic                           I_RELOCK,
    output logic                           O_UNLOCKED,
    output logic                           O_LOCKOUT,
    output logic                           O_FAIL,
    output logic                           O_PROG_DONE,
    output logic [$clog2(MAX_FAILS+1)-1:0] O_FAIL_CNT
);

    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT);

    state_t              state;
    logic [CODE_LEN-1:0] code_reg;
    logic [CODE_LEN-2:0] shadow;
    logic [CODE_LEN-1:0] shadow_nxt;
    logic [CODE_LEN-1:0] bit_mask;
    logic [CW-1:0]       bit_cnt;
    logic                match;
    logic [FW-1:0]       fail_cnt;
    logic [FW-1:0]       fail_nxt;
    logic                o_fail;
    logic                o_prog_done;

    logic                last_bit;
    logic                bit_ok;
    logic                all_ok;
    logic                lock_trip;
    logic                tmr_load;
    logic                tmr_clr;
    logic                tmr_exp;
    logic [TW-1:0]       tmr_val;

    // Select the expected code bit with a walking mask rather than a variable index.
    assign bit_mask   = {1'b1, {(CODE_LEN-1){1'b0}}} >> bit_cnt;
    assign bit_ok     = (I_BIT == |(code_reg & bit_mask));
    assign last_bit   = (bit_cnt == CW'(CODE_LEN - 1));
    assign all_ok     = match & bit_ok;
    assign fail_nxt   = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + FW'(1);
    assign lock_trip  = (fail_nxt == FW'(MAX_FAILS));
    assign shadow_nxt = {shadow, I_BIT};

    // One timer serves unlock, lockout and inter-bit timeout; the states never overlap.
    always_comb begin
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        tmr_val  = '0;
        case (state)
            ENTRY: begin
                if (I_VALID) begin
                    if (!last_bit) begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(ENTRY_TIMEOUT);
                    end else if (all_ok) begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(UNLOCK_CYCLES);
                    end else if (lock_trip) begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(LOCKOUT_CYCLES);
                    end else begin
                        tmr_clr = 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                if (tmr_exp || I_RELOCK) begin
                    tmr_clr = 1'b1;
                end else if (I_PROG) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ENTRY_TIMEOUT);
                end
            end
            PROG: begin
                if (I_VALID) begin
                    if (last_bit) begin
                        tmr_clr = 1'b1;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(ENTRY_TIMEOUT);
                    end
                end
            end
            default: ;
        endcase
    end

    lock_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clr      (tmr_clr),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ENTRY;
            code_reg    <= DEFAULT_CODE;
            shadow      <= '0;
            bit_cnt     <= '0;
            match       <= 1'b0;
            fail_cnt    <= '0;
            o_fail      <= 1'b0;
            o_prog_done <= 1'b0;
        end else begin
            o_fail      <= 1'b0;
            o_prog_done <= 1'b0;
            case (state)
                ENTRY: begin
                    if (I_VALID) begin
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (all_ok) begin
                                state    <= UNLOCKED;
                                fail_cnt <= '0;
                            end else begin
                                o_fail   <= 1'b1;
                                fail_cnt <= fail_nxt;
                                if (lock_trip) state <= LOCKOUT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                            match   <= (bit_cnt == '0) ? bit_ok : (match & bit_ok);
                        end
                    end else if (bit_cnt != '0 && tmr_exp) begin
                        bit_cnt <= '0;
                    end
                end
                UNLOCKED: begin
                    if (tmr_exp || I_RELOCK) begin
                        state <= ENTRY;
                    end else if (I_PROG) begin
                        state   <= PROG;
                        bit_cnt <= '0;
                    end
                end
                PROG: begin
                    if (I_VALID) begin
                        shadow <= shadow_nxt[CODE_LEN-2:0];
                        if (last_bit) begin
                            code_reg    <= shadow_nxt;
                            o_prog_done <= 1'b1;
                            state       <= ENTRY;
                            bit_cnt     <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (tmr_exp) begin
                        state   <= ENTRY;
                        bit_cnt <= '0;
                    end
                end
                LOCKOUT: begin
                    if (tmr_exp) begin
                        state    <= ENTRY;
                        fail_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                default: begin
                    state   <= ENTRY;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign O_UNLOCKED  = (state == UNLOCKED);
    assign O_LOCKOUT   = (state == LOCKOUT);
    assign O_FAIL      = o_fail;
    assign O_PROG_DONE = o_prog_done;
    assign O_FAIL_CNT  = fail_cnt;

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Directed vector bench for digital_lock_ctrl with a 4-bit code 1011.
module tb_digital_lock_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_valid = 1'b0, i_bit = 1'b0, i_prog = 1'b0, i_relock = 1'b0;
    logic       o_unl, o_lko, o_fail, o_pd;
    logic [1:0] o_fc;

    always #5 clk = ~clk;

    digital_lock_ctrl #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (4'b1011),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (8),
        .UNLOCK_CYCLES  (10),
        .ENTRY_TIMEOUT  (5)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .I_VALID     (i_valid),
        .I_BIT       (i_bit),
        .I_PROG      (i_prog),
        .I_RELOCK    (i_relock),
        .O_UNLOCKED  (o_unl),
        .O_LOCKOUT   (o_lko),
        .O_FAIL      (o_fail),
        .O_PROG_DONE (o_pd),
        .O_FAIL_CNT  (o_fc)
    );

    // Inputs for one cycle and the outputs expected in the following cycle.
    typedef struct {
        logic       v, b, p, r;
        logic       unl, lko, fail, pd;
        logic [1:0] fc;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   failures = 0;
    int   rown = 0;

    task automatic chk(input string name, input int row, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0d exp=%0d", name, row, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic b, input logic p, input logic r,
                                input logic unl, input logic lko, input logic fail,
                                input logic pd, input logic [1:0] fc);
        vec_t t;
        t.v = v; t.b = b; t.p = p; t.r = r;
        t.unl = unl; t.lko = lko; t.fail = fail; t.pd = pd; t.fc = fc;
        vq.push_back(t);
    endfunction

    function automatic void idle(input int n, input logic unl, input logic lko, input logic [1:0] fc);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, unl, lko, 0, 0, fc);
    endfunction

    // Four bits MSB first; only the last one may change the outputs.
    function automatic void add_code(input logic [3:0] c, input logic [1:0] fc0,
                                     input logic unl, input logic fail, input logic lko,
                                     input logic pd, input logic [1:0] fc1);
        for (int i = 0; i < 3; i++) add(1, c[3-i], 0, 0, 0, 0, 0, 0, fc0);
        add(1, c[0], 0, 0, unl, lko, fail, pd, fc1);
    endfunction

    function automatic void relock();
        add(0, 0, 0, 1, 0, 0, 0, 0, 2'd0);
    endfunction

    function automatic void prog();
        add(0, 0, 1, 0, 0, 0, 0, 0, 2'd0);
    endfunction

    task automatic run_q();
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            i_valid = vq[i].v; i_bit = vq[i].b; i_prog = vq[i].p; i_relock = vq[i].r;
            @(posedge clk);
            #1;
            chk("unlocked",  rown, {1'b0, o_unl},  {1'b0, vq[i].unl});
            chk("lockout",   rown, {1'b0, o_lko},  {1'b0, vq[i].lko});
            chk("fail",      rown, {1'b0, o_fail}, {1'b0, vq[i].fail});
            chk("prog_done", rown, {1'b0, o_pd},   {1'b0, vq[i].pd});
            chk("fail_cnt",  rown, o_fc,           vq[i].fc);
            rown++;
        end
        vq.delete();
        @(negedge clk);
        i_valid = 0; i_bit = 0; i_prog = 0; i_relock = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_unlocked"},  rown, {1'b0, o_unl},  2'd0);
        chk({tag, "_lockout"},   rown, {1'b0, o_lko},  2'd0);
        chk({tag, "_fail"},      rown, {1'b0, o_fail}, 2'd0);
        chk({tag, "_prog_done"}, rown, {1'b0, o_pd},   2'd0);
        chk({tag, "_fail_cnt"},  rown, o_fc,           2'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) rstn = 1'b1;

        // Correct code with gaps, full unlock window, expiry beats a same-cycle I_PROG.
        add(1, 1, 0, 0, 0, 0, 0, 0, 0); idle(1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0); idle(2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0);
        idle(9, 1, 0, 0);
        prog();
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); relock();

        // Three wrong entries, lockout ignores the correct code, then unlock.
        add_code(4'b1111, 0, 0, 1, 0, 0, 1); idle(1, 0, 0, 1);
        add_code(4'b1111, 1, 0, 1, 0, 0, 2); idle(1, 0, 0, 2);
        add_code(4'b1111, 2, 0, 1, 1, 0, 3);
        add(1, 1, 0, 0, 0, 1, 0, 0, 3); add(1, 0, 0, 0, 0, 1, 0, 0, 3);
        add(1, 1, 0, 0, 0, 1, 0, 0, 3); add(1, 1, 0, 0, 0, 1, 0, 0, 3);
        idle(3, 0, 1, 3);
        idle(1, 0, 0, 0);
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); relock();

        // Five idle cycles discard a partial entry; four do not.
        add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5, 0, 0, 0);
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); relock();
        add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 1, 0, 0, 0, 0); relock();

        // I_RELOCK wins over I_PROG: following 1011 must unlock, not program.
        add_code(4'b1011, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0); idle(1, 0, 0, 0);
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); relock();

        // Reprogram to 0110: old code fails, new code unlocks.
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); prog();
        add_code(4'b0110, 0, 0, 0, 0, 1, 0); idle(1, 0, 0, 0);
        add_code(4'b1011, 0, 0, 1, 0, 0, 1); idle(1, 0, 0, 1);
        add_code(4'b0110, 1, 1, 0, 0, 0, 0); relock();

        // Enter PROG again and shift two bits before reset.
        add_code(4'b0110, 0, 1, 0, 0, 0, 0); prog();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_q();

        rstn = 1'b0;
        #1 chk_all_zero("midprog_rst");
        @(negedge clk) rstn = 1'b1;

        // Default code is back; then a stalled PROG aborts without committing.
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); relock();
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); prog();
        add(1, 1, 0, 0, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(5, 0, 0, 0);
        add_code(4'b1011, 0, 1, 0, 0, 0, 0); relock();
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
